// File: rtl/ifid_hazard_stage_if.sv
// rtl/ifid_hazard_stage_if.sv - fetch/ID-EX/hazard bundle between the pipeline and the IF/ID stage
//
// Purpose: groups the fetch inputs, ID/EX feedback, hazard outputs and IF/ID
// register outputs of ifid_hazard_stage into one bundle.
// Ports (signals):
//   pc4_in, instr_in          fetched PC+4 and instruction word
//   idex_MemRead, idex_rt     load indication and destination held in ID/EX
//   branch_taken              branch resolved taken in EX this cycle
//   pc_write, ctrl_bubble     hazard controls (combinational)
//   ifid_pc4_out, ifid_instr_out, ifid_valid_out   registered IF/ID contents
//   stall_count, flush_count  saturating event counters
// Modports: master drives the fetch/EX side, slave is the IF/ID stage.
interface ifid_hazard_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc4_in;
    logic [31:0]      instr_in;
    logic             idex_MemRead;
    logic [4:0]       idex_rt;
    logic             branch_taken;
    logic             pc_write;
    logic             ctrl_bubble;
    logic [31:0]      ifid_pc4_out;
    logic [31:0]      ifid_instr_out;
    logic             ifid_valid_out;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output pc4_in, instr_in, idex_MemRead, idex_rt, branch_taken,
        input  pc_write, ctrl_bubble, ifid_pc4_out, ifid_instr_out,
               ifid_valid_out, stall_count, flush_count
    );

    modport slave (
        input  pc4_in, instr_in, idex_MemRead, idex_rt, branch_taken,
        output pc_write, ctrl_bubble, ifid_pc4_out, ifid_instr_out,
               ifid_valid_out, stall_count, flush_count
    );
endinterface

// File: rtl/ifid_hazard_stage.sv
// rtl/ifid_hazard_stage.sv - IF/ID pipeline register with load-use stall and branch flush
//
// Purpose: holds the fetched PC+4/instruction for decode, stalls one cycle on a
// load-use hazard against the load in ID/EX, squashes the entry on a taken
// branch, and counts stall/flush cycles with saturating counters.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ifid_hazard_stage_if slave modport (see interface header)
module ifid_hazard_stage #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ifid_hazard_stage_if.slave   bus
);
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             load_use;
    logic             pc_write;
    logic             ctrl_bubble;

    assign rs_id = instr_q[25:21];
    assign rt_id = instr_q[20:16];

    // $zero as load destination is never a hazard; a squashed entry never stalls.
    assign load_use = valid_q & bus.idex_MemRead & (bus.idex_rt != 5'd0)
                    & ((bus.idex_rt == rs_id) | (bus.idex_rt == rt_id));

    always_comb begin
        pc_write    = 1'b1;
        ctrl_bubble = 1'b0;
        pc4_d       = bus.pc4_in;
        instr_d     = bus.instr_in;
        valid_d     = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (reset) begin
            pc_write    = 1'b0;
            ctrl_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            // Flush beats stall: the stalled instruction is on the wrong path anyway.
            ctrl_bubble = 1'b1;
            pc4_d       = 32'h0;
            instr_d     = 32'h0;
            valid_d     = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            ctrl_bubble = 1'b1;
            pc4_d       = pc4_q;
            instr_d     = instr_q;
            valid_d     = valid_q;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc4_q       <= 32'h0;
            instr_q     <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write       = pc_write;
    assign bus.ctrl_bubble    = ctrl_bubble;
    assign bus.ifid_pc4_out   = pc4_q;
    assign bus.ifid_instr_out = instr_q;
    assign bus.ifid_valid_out = valid_q;
    assign bus.stall_count    = stall_cnt_q;
    assign bus.flush_count    = flush_cnt_q;
endmodule

// File: tb/tb_ifid_hazard_stage.sv
// tb/tb_ifid_hazard_stage.sv - self-checking bench for ifid_hazard_stage
module tb_ifid_hazard_stage;
    localparam logic [31:0] ADD_123 = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] ADD_300 = 32'h00001820;  // add $3,$0,$0

    logic        clk;
    logic        reset;
    logic [31:0] pc4_in;
    logic [31:0] instr_in;
    logic        mem_read;
    logic [4:0]  idex_rt;
    logic        branch_taken;

    int n_checks;
    int n_pass;

    ifid_hazard_stage_if #(.CNT_W(16)) bus_a ();
    ifid_hazard_stage_if #(.CNT_W(2))  bus_b ();

    assign bus_a.pc4_in       = pc4_in;
    assign bus_a.instr_in     = instr_in;
    assign bus_a.idex_MemRead = mem_read;
    assign bus_a.idex_rt      = idex_rt;
    assign bus_a.branch_taken = branch_taken;
    assign bus_b.pc4_in       = pc4_in;
    assign bus_b.instr_in     = instr_in;
    assign bus_b.idex_MemRead = mem_read;
    assign bus_b.idex_rt      = idex_rt;
    assign bus_b.branch_taken = branch_taken;

    ifid_hazard_stage #(.CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ifid_hazard_stage #(.CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural IF/ID contents plus raw (unsaturated) event counts.
    bit          m_init;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_stalls;
    int          m_flushes;

    function automatic bit model_hazard();
        logic [4:0] rs;
        logic [4:0] rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        return m_valid && mem_read && idex_rt != 0 && (idex_rt == rs || idex_rt == rt);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;
            m_init = 1;
        end else if (m_init) begin
            if (branch_taken) begin
                m_pc4 = 0; m_instr = 0; m_valid = 0; m_flushes++;
            end else if (model_hazard()) begin
                m_stalls++;
            end else begin
                m_pc4 = pc4_in; m_instr = instr_in; m_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            bit exp_pw;
            bit exp_bub;
            if (reset) begin
                exp_pw = 0; exp_bub = 1;
            end else if (branch_taken) begin
                exp_pw = 1; exp_bub = 1;
            end else if (model_hazard()) begin
                exp_pw = 0; exp_bub = 1;
            end else begin
                exp_pw = 1; exp_bub = 0;
            end
            check("cmp_pc_write",    {31'd0, bus_a.pc_write},       {31'd0, exp_pw});
            check("cmp_ctrl_bubble", {31'd0, bus_a.ctrl_bubble},    {31'd0, exp_bub});
            check("cmp_pc4_out",     bus_a.ifid_pc4_out,            m_pc4);
            check("cmp_instr_out",   bus_a.ifid_instr_out,          m_instr);
            check("cmp_valid_out",   {31'd0, bus_a.ifid_valid_out}, {31'd0, m_valid});
            check("cmp_stall16",     {16'd0, bus_a.stall_count},    sat(m_stalls, 16));
            check("cmp_flush16",     {16'd0, bus_a.flush_count},    sat(m_flushes, 16));
            check("cmp_pc_write_w2", {31'd0, bus_b.pc_write},       {31'd0, exp_pw});
            check("cmp_stall2",      {30'd0, bus_b.stall_count},    sat(m_stalls, 2));
            check("cmp_flush2",      {30'd0, bus_b.flush_count},    sat(m_flushes, 2));
        end
    end

    task automatic drive(input bit rst, input logic [31:0] pc4, input logic [31:0] instr,
                         input bit mr, input logic [4:0] rt, input bit bt);
        reset = rst; pc4_in = pc4; instr_in = instr;
        mem_read = mr; idex_rt = rt; branch_taken = bt;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        m_init = 0;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        // 1. reset
        check("rst_pc4",         bus_a.ifid_pc4_out, 32'd0);
        check("rst_valid",       {31'd0, bus_a.ifid_valid_out}, 32'd0);
        check("rst_pc_write",    {31'd0, bus_a.pc_write}, 32'd0);
        check("rst_bubble",      {31'd0, bus_a.ctrl_bubble}, 32'd1);
        drive(0, 32'd4, ADD_123, 0, 0, 0);
        #1;
        check("post_rst_pc_write", {31'd0, bus_a.pc_write}, 32'd1);
        check("post_rst_bubble",   {31'd0, bus_a.ctrl_bubble}, 32'd0);
        tick();
        check("first_pc4", bus_a.ifid_pc4_out, 32'd4);
        check("first_valid", {31'd0, bus_a.ifid_valid_out}, 32'd1);
        // 2. stream
        drive(0, 32'd8, ADD_123, 0, 0, 0);  tick();
        drive(0, 32'd12, ADD_123, 0, 0, 0); tick();
        check("stream_pc4",   bus_a.ifid_pc4_out, 32'd12);
        check("stream_instr", bus_a.ifid_instr_out, ADD_123);
        check("stream_stall", {16'd0, bus_a.stall_count}, 32'd0);
        // 3. load-use stall: lw $2 in ID/EX vs add $3,$1,$2 in IF/ID
        drive(0, 32'd16, ADD_300, 1, 5'd2, 0);
        #1;
        check("stall_pc_write", {31'd0, bus_a.pc_write}, 32'd0);
        check("stall_bubble",   {31'd0, bus_a.ctrl_bubble}, 32'd1);
        tick();
        check("stall_hold_pc4", bus_a.ifid_pc4_out, 32'd12);
        check("stall_count1",   {16'd0, bus_a.stall_count}, 32'd1);
        drive(0, 32'd16, ADD_300, 0, 5'd0, 0);
        #1;
        check("stall_over_pc_write", {31'd0, bus_a.pc_write}, 32'd1);
        tick();
        check("resume_pc4",   bus_a.ifid_pc4_out, 32'd16);
        check("resume_instr", bus_a.ifid_instr_out, ADD_300);
        // 4. idex_rt==0 never stalls
        drive(0, 32'd20, ADD_123, 1, 5'd0, 0);
        #1;
        check("zero_rt_pc_write", {31'd0, bus_a.pc_write}, 32'd1);
        tick();
        check("zero_rt_pc4", bus_a.ifid_pc4_out, 32'd20);
        // 5. branch coincident with load-use: flush wins
        drive(0, 32'd24, ADD_300, 1, 5'd2, 1);
        #1;
        check("flush_pc_write", {31'd0, bus_a.pc_write}, 32'd1);
        check("flush_bubble",   {31'd0, bus_a.ctrl_bubble}, 32'd1);
        tick();
        check("flush_instr", bus_a.ifid_instr_out, 32'd0);
        check("flush_valid", {31'd0, bus_a.ifid_valid_out}, 32'd0);
        check("flush_count", {16'd0, bus_a.flush_count}, 32'd1);
        check("flush_stall_same", {16'd0, bus_a.stall_count}, 32'd1);
        // 6. saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'd100 + 32'(i * 4), ADD_123, 0, 0, 0); tick();
            drive(0, 32'd200, ADD_300, 1, 5'd2, 0);           tick();
        end
        check("sat_stall_w2",  {30'd0, bus_b.stall_count}, 32'd3);
        check("sat_stall_w16", {16'd0, bus_a.stall_count}, 32'd5);
        drive(0, 32'd120, ADD_123, 0, 0, 0); tick();
        drive(1, 32'd200, ADD_300, 1, 5'd2, 0);
        #1;
        check("rst_mid_stall_pc_write", {31'd0, bus_a.pc_write}, 32'd0);
        tick();
        check("rst_mid_stall_cnt_w2", {30'd0, bus_b.stall_count}, 32'd0);
        check("rst_mid_flush_cnt",    {16'd0, bus_a.flush_count}, 32'd0);
        check("rst_mid_valid",        {31'd0, bus_a.ifid_valid_out}, 32'd0);
        drive(0, 32'd300, ADD_123, 0, 0, 0); tick();
        check("after_rst_pc4", bus_a.ifid_pc4_out, 32'd300);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
